// File: rtl/div4_pkg.sv
// Shared types and constants for the 4-bit streaming divider stage.
// The remainder path is compiled in only when DIV4_REM_EN is defined.
package div4_pkg;

  localparam int         DIV4_FIFO_DEPTH = 2;
  localparam logic [3:0] DIV4_DZ_QUOT    = 4'hF;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } div4_op_t;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } div4_res_t;

endpackage

// File: rtl/div4_stream_stage_if.sv
// Operand/result handshake bundle for div4_stream_stage.
// out_r exists only when DIV4_REM_EN is defined.
interface div4_stream_stage_if;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_q;
  logic       out_dz;
`ifdef DIV4_REM_EN
  logic [3:0] out_r;
`endif

  // Producer/consumer side of the stage.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_q, out_dz
`ifdef DIV4_REM_EN
    , input out_r
`endif
  );

  // The divider stage itself.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_q, out_dz
`ifdef DIV4_REM_EN
    , output out_r
`endif
  );

endinterface

// File: rtl/div4_core.sv
// Combinational 4-bit restoring divider core (a3..a0 / b3..b0 -> o3..o0).
// Output is meaningless for a zero divisor; callers must mask that case.
module div4_core (
  input  logic a3,
  input  logic a2,
  input  logic a1,
  input  logic a0,
  input  logic b3,
  input  logic b2,
  input  logic b1,
  input  logic b0,
  output logic o3,
  output logic o2,
  output logic o1,
  output logic o0
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] quot;
  logic [4:0] part;

  assign a = {a3, a2, a1, a0};
  assign b = {b3, b2, b1, b0};

  // NOTE: combinational blocks use blocking '=' so each loop iteration sees the
  // partial remainder produced by the previous one; clocked blocks use '<='.
  always_comb begin
    part = '0;
    quot = '0;
    for (int i = 3; i >= 0; i--) begin
      part = {part[3:0], a[i]};
      if (part >= {1'b0, b}) begin
        part    = part - {1'b0, b};
        quot[i] = 1'b1;
      end
    end
  end

  assign {o3, o2, o1, o0} = quot;

endmodule

// File: rtl/div4_op_fifo.sv
// Two-entry operand FIFO with registered occupancy count.
// Push is ignored when full, pop is ignored when empty.
module div4_op_fifo
  import div4_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  div4_op_t wdata,
  output div4_op_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DIV4_FIFO_DEPTH);
  localparam int CNT_W = $clog2(DIV4_FIFO_DEPTH + 1);

  div4_op_t   mem_q [DIV4_FIFO_DEPTH];
  div4_op_t   mem_d [DIV4_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic do_push;
  logic do_pop;

  assign full  = (count_q == CNT_W'(DIV4_FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is left unreset; the count gates every read, so stale
  // entries are never observed and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/div4_stream_stage.sv
// Valid/ready wrapper around div4_core: operand FIFO, registered result,
// divide-by-zero handling and saturating dz counter. Remainder via DIV4_REM_EN.
module div4_stream_stage
  import div4_pkg::*;
#(
  parameter int DZ_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  div4_stream_stage_if.slave  io,
  output logic [DZ_CNT_W-1:0] dz_cnt
);

  div4_op_t  head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      push;
  logic      pop;
  logic      out_xfer;
  logic [3:0] core_q;
  div4_res_t head_res;

  div4_res_t           res_q, res_d;
  logic                out_valid_q, out_valid_d;
  logic [DZ_CNT_W-1:0] dz_cnt_q, dz_cnt_d;

  // in_ready depends only on the registered FIFO count, never on out_ready.
  assign io.in_ready = !fifo_full;
  assign push        = io.in_valid && !fifo_full;
  assign out_xfer    = out_valid_q && io.out_ready;
  assign pop         = !fifo_empty && (!out_valid_q || io.out_ready);

  div4_op_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({io.in_a, io.in_b}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  div4_core u_core (
    .a3 (head.a[3]),
    .a2 (head.a[2]),
    .a1 (head.a[1]),
    .a0 (head.a[0]),
    .b3 (head.b[3]),
    .b2 (head.b[2]),
    .b1 (head.b[1]),
    .b0 (head.b[0]),
    .o3 (core_q[3]),
    .o2 (core_q[2]),
    .o1 (core_q[1]),
    .o0 (core_q[0])
  );

  always_comb begin
    head_res = '0;
    if (head.b == '0) begin
      head_res.q  = DIV4_DZ_QUOT;
      head_res.dz = 1'b1;
    end else begin
      head_res.q  = core_q;
    end
`ifdef DIV4_REM_EN
    // q*b never exceeds a, so the 4-bit subtraction cannot wrap.
    if (head.b == '0) begin
      head_res.r = head.a;
    end else begin
      head_res.r = head.a - 4'(core_q * head.b);
    end
`else
    head_res.r = '0;
`endif
  end

  always_comb begin
    res_d       = res_q;
    out_valid_d = out_valid_q;
    dz_cnt_d    = dz_cnt_q;
    if (out_xfer) begin
      out_valid_d = 1'b0;
      if (res_q.dz && (dz_cnt_q != '1)) begin
        dz_cnt_d = dz_cnt_q + DZ_CNT_W'(1);
      end
    end
    if (pop) begin
      out_valid_d = 1'b1;
      res_d       = head_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      dz_cnt_q    <= '0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      dz_cnt_q    <= dz_cnt_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_q     = res_q.q;
  assign io.out_dz    = res_q.dz;
  assign dz_cnt       = dz_cnt_q;

`ifdef DIV4_REM_EN
  assign io.out_r = res_q.r;
`else
  // The r field is constant zero here and has no consumer.
  logic unused_r;
  assign unused_r = ^res_q.r;
`endif

endmodule

// File: tb/tb_div4_stream_stage.sv
// Self-checking bench for div4_stream_stage: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_div4_stream_stage;
  import div4_pkg::*;

  localparam int CW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] dz_cnt;

  div4_stream_stage_if io();

  div4_stream_stage #(.DZ_CNT_W(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io     (io.slave),
    .dz_cnt (dz_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending operands, output slot, delivered-dz count.
  div4_op_t  m_fifo[$];
  logic      m_ov;
  div4_res_t m_res;
  int        m_cnt;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic div4_res_t golden(input logic [3:0] a, input logic [3:0] b);
    div4_res_t res;
    if (b == 4'd0) begin
      res.q = 4'hF; res.r = a; res.dz = 1'b1;
    end else begin
      res.q = 4'(a / b); res.r = 4'(a % b); res.dz = 1'b0;
    end
    return res;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_ov  = 1'b0;
    m_res = '0;
    m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready"},  32'(io.in_ready),  32'(m_fifo.size() < 2));
    check({tag, ".out_valid"}, 32'(io.out_valid), 32'(m_ov));
    if (m_ov) begin
      check({tag, ".out_q"},  32'(io.out_q),  32'(m_res.q));
      check({tag, ".out_dz"}, 32'(io.out_dz), 32'(m_res.dz));
`ifdef DIV4_REM_EN
      check({tag, ".out_r"},  32'(io.out_r),  32'(m_res.r));
`endif
    end
    check({tag, ".dz_cnt"}, 32'(dz_cnt), 32'(m_cnt));
  endtask

  // One clock edge with the current inputs; the model advances, then all outputs are checked.
  task automatic step(input string tag);
    bit       do_push, do_pop, do_xfer;
    div4_op_t op;
    op      = '{a: io.in_a, b: io.in_b};
    do_push = io.in_valid && (m_fifo.size() < 2);
    do_xfer = m_ov && io.out_ready;
    do_pop  = (m_fifo.size() > 0) && (!m_ov || io.out_ready);
    @(posedge clk);
    if (do_xfer && m_res.dz && m_cnt < (2**CW - 1)) m_cnt++;
    if (do_pop) begin
      op    = m_fifo.pop_front();
      m_res = golden(op.a, op.b);
      m_ov  = 1'b1;
      op    = '{a: io.in_a, b: io.in_b};
    end else if (do_xfer) begin
      m_ov = 1'b0;
    end
    if (do_push) m_fifo.push_back(op);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
    io.in_valid = v;
    io.in_a     = a;
    io.in_b     = b;
  endtask

  initial begin
    logic [3:0] got[$];
    logic [3:0] bp_exp[4];
    logic [3:0] bp_a[4];
    logic [3:0] bp_b[4];
    logic       accept;
    div4_res_t  g;

    vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0};
    vecs[1] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
    vecs[2] = '{4'd7,  4'd0,  4'hF,  4'd7,  1'b1};
    vecs[3] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0};
    vecs[4] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
    vecs[5] = '{4'd1,  4'd15, 4'd0,  4'd1,  1'b0};
    vecs[6] = '{4'd14, 4'd4,  4'd3,  4'd2,  1'b0};
    vecs[7] = '{4'd0,  4'd0,  4'hF,  4'd0,  1'b1};
    vecs[8] = '{4'd9,  4'd8,  4'd1,  4'd1,  1'b0};
    vecs[9] = '{4'd15, 4'd7,  4'd2,  4'd1,  1'b0};
    bp_a = '{4'd9, 4'd8, 4'd6, 4'd5};
    bp_b = '{4'd2, 4'd4, 4'd5, 4'd1};
    bp_exp = '{4'd4, 4'd2, 4'd1, 4'd5};

    drive(1'b0, 4'd0, 4'd0);
    io.out_ready = 1'b0;
    apply_reset();

    check("reset.in_ready",  32'(io.in_ready),  32'd1);
    check("reset.out_valid", 32'(io.out_valid), 32'd0);
    check("reset.out_q",     32'(io.out_q),     32'd0);
    check("reset.out_dz",    32'(io.out_dz),    32'd0);
`ifdef DIV4_REM_EN
    check("reset.out_r",     32'(io.out_r),     32'd0);
`endif
    check("reset.dz_cnt",    32'(dz_cnt),       32'd0);

    // Single ops from the table: two-cycle latency, then drain.
    io.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b);
      step("vec_accept");
      drive(1'b0, 4'd0, 4'd0);
      check("vec.latency_not_yet", 32'(io.out_valid), 32'd0);
      step("vec_load");
      check("vec.out_valid", 32'(io.out_valid), 32'd1);
      check("vec.out_q",     32'(io.out_q),     32'(vecs[i].q));
      check("vec.out_dz",    32'(io.out_dz),    32'(vecs[i].dz));
`ifdef DIV4_REM_EN
      check("vec.out_r",     32'(io.out_r),     32'(vecs[i].r));
`endif
      step("vec_drain");
    end
    check("vec.dz_cnt_total", 32'(dz_cnt), 32'd2);

    // Backpressure: three accepted, fourth stalls, order preserved.
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, bp_a[k], bp_b[k]);
      step("bp_fill");
    end
    drive(1'b1, bp_a[3], bp_b[3]);
    check("bp.full_in_ready", 32'(io.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step("bp_hold");
      check("bp.hold_q", 32'(io.out_q), 32'd4);
    end
    io.out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 12 && got.size() < 4; c++) begin
      if (io.out_valid) got.push_back(io.out_q);
      accept = io.in_valid && io.in_ready;
      step("bp_drain");
      if (accept) io.in_valid = 1'b0;
    end
    check("bp.result_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < got.size(); k++) check("bp.order_q", 32'(got[k]), 32'(bp_exp[k]));

    // Streaming: 16 back-to-back ops, one result every cycle.
    apply_reset();
    io.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) drive(1'b1, 4'(c), 4'(c % 4 + 1));
      else        drive(1'b0, 4'd0, 4'd0);
      step("stream");
      if (c >= 1 && c <= 16) begin
        g = golden(4'(c - 1), 4'((c - 1) % 4 + 1));
        check("stream.valid", 32'(io.out_valid), 32'd1);
        check("stream.q",     32'(io.out_q),     32'(g.q));
`ifdef DIV4_REM_EN
        check("stream.r",     32'(io.out_r),     32'(g.r));
`endif
      end else begin
        check("stream.idle", 32'(io.out_valid), 32'd0);
      end
    end

    // Saturation: 260 divide-by-zero results.
    apply_reset();
    io.out_ready = 1'b1;
    for (int c = 0; c < 263; c++) begin
      if (c < 260) drive(1'b1, 4'(c), 4'd0);
      else         drive(1'b0, 4'd0, 4'd0);
      step("sat");
    end
    check("sat.dz_cnt", 32'(dz_cnt), 32'd255);

    // Reset mid-flight with three ops buffered.
    io.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'(k + 10), 4'(k + 1));
      step("mid_fill");
    end
    drive(1'b0, 4'd0, 4'd0);
    check("mid.pre_valid", 32'(io.out_valid), 32'd1);
    check("mid.pre_full",  32'(io.in_ready),  32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.rst_out_valid", 32'(io.out_valid), 32'd0);
    check("mid.rst_out_q",     32'(io.out_q),     32'd0);
    check("mid.rst_out_dz",    32'(io.out_dz),    32'd0);
`ifdef DIV4_REM_EN
    check("mid.rst_out_r",     32'(io.out_r),     32'd0);
`endif
    check("mid.rst_in_ready",  32'(io.in_ready),  32'd1);
    check("mid.rst_dz_cnt",    32'(dz_cnt),       32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step("mid_after");
      check("mid.no_stale", 32'(io.out_valid), 32'd0);
    end

    // Random traffic against the model.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
      io.out_ready = 1'($urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (tests=%0d failed=%0d)", n_tests, n_fail);
    $fatal(1);
  end

endmodule
